// File: rtl/conv1_frame_sched_pkg.sv
// Shared constants, FSM encoding and output-tag layout for the conv1 frame scheduler.
package conv1_frame_sched_pkg;

    localparam int IMG_W    = 28;  // frame width in pixels
    localparam int IMG_H    = 28;  // frame height in pixels
    localparam int K        = 5;   // conv1 kernel size
    localparam int CONV_LAT = 2;   // accepted beat -> conv1 result stable
    localparam int CLR_CYC  = 2;   // cycles conv1 is held in reset at job start
    localparam int FRM_W    = 8;   // frame count / frame index width
    localparam int PIX_W    = 8;   // grayscale pixel width
    localparam int COORD_W  = 5;   // pixel and output coordinate width
    localparam int CNT_W    = 4;   // width of the CLR / DRAIN cycle counters

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    // One entry of the latency-matching pipe that travels alongside conv1.
    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               last;
    } tag_t;

    // Input coordinate -> output coordinate (first output sits at K-1,K-1).
    function automatic logic [COORD_W-1:0] out_coord(input logic [COORD_W-1:0] p);
        return p - COORD_W'(K - 1);
    endfunction

endpackage

// File: rtl/conv1_frame_sched_tag_pipe.sv
// Fixed-depth shift register that delays output tags by conv1's pipeline latency.
module conv1_frame_sched_tag_pipe
    import conv1_frame_sched_pkg::*;
#(
    parameter int DEPTH = CONV_LAT
) (
    input  logic clk,
    input  logic clr_i,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t stage_q [DEPTH];

    // Shift one stage per cycle; a clear drops every pending tag.
    // NOTE: the whole array is cleared, not just the valid bits, because the
    // coordinate fields drive ports that must read zero straight after reset.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/conv1_frame_sched.sv
// Frame scheduler for conv1: clears the engine at job start, streams 28x28
// frames back-to-back from a valid/ready source, and emits a qualified output
// strobe with output coordinates aligned to conv1's result latency.
module conv1_frame_sched
    import conv1_frame_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRM_W-1:0]   num_frames,
    output logic               busy,
    output logic               done,
    output logic [FRM_W-1:0]   frame_idx,
    input  logic [PIX_W-1:0]   src_data,
    input  logic               src_valid,
    output logic               src_ready,
    output logic               conv_rst_n,
    output logic [PIX_W-1:0]   conv_data_in,
    output logic               conv_data_in_valid,
    output logic               out_valid,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_last
);

    localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(IMG_H - 1);
    localparam logic [COORD_W-1:0] K_EDGE  = COORD_W'(K - 1);
    localparam logic [CNT_W-1:0]   CLR_END = CNT_W'(CLR_CYC - 1);
    // DRAIN ends when the last tag reaches the pipe output, so done lines up
    // with the final out_valid of the job.
    localparam logic [CNT_W-1:0]   DRN_END = CNT_W'((CONV_LAT > 1) ? CONV_LAT - 2 : 0);
    localparam state_t             AFTER_FEED = (CONV_LAT > 1) ? S_DRAIN : S_DONE;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [CNT_W-1:0]   drn_cnt_q, drn_cnt_d;
    logic [COORD_W-1:0] px_q, px_d;
    logic [COORD_W-1:0] py_q, py_d;
    logic [FRM_W-1:0]   frame_q, frame_d;
    logic [FRM_W-1:0]   last_frame_q, last_frame_d;
    logic               conv_rst_n_q;

    logic beat;
    tag_t tag_in;
    tag_t tag_out;

    assign src_ready          = (state_q == S_FEED);
    assign beat               = src_valid & src_ready;
    assign conv_data_in       = src_data;
    assign conv_data_in_valid = beat;
    assign busy               = (state_q != S_IDLE);
    assign done               = (state_q == S_DONE);
    assign frame_idx          = frame_q;
    assign conv_rst_n         = conv_rst_n_q;

    // Next-state logic: FSM transitions plus pixel/row/frame counting on beats.
    // NOTE: every _d is defaulted to its _q first so no path leaves a latch.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        drn_cnt_d    = drn_cnt_q;
        px_d         = px_q;
        py_d         = py_q;
        frame_d      = frame_q;
        last_frame_d = last_frame_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    px_d         = '0;
                    py_d         = '0;
                    frame_d      = '0;
                    clr_cnt_d    = '0;
                    last_frame_d = num_frames - FRM_W'(1);
                    state_d      = (num_frames == '0) ? S_DONE : S_CLR;
                end
            end
            S_CLR: begin
                if (clr_cnt_q == CLR_END) begin
                    state_d = S_FEED;
                end else begin
                    clr_cnt_d = clr_cnt_q + CNT_W'(1);
                end
            end
            S_FEED: begin
                if (beat) begin
                    if (px_q != X_MAX) begin
                        px_d = px_q + COORD_W'(1);
                    end else begin
                        px_d = '0;
                        if (py_q != Y_MAX) begin
                            py_d = py_q + COORD_W'(1);
                        end else begin
                            py_d    = '0;
                            frame_d = frame_q + FRM_W'(1);
                            if (frame_q == last_frame_q) begin
                                drn_cnt_d = '0;
                                state_d   = AFTER_FEED;
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (drn_cnt_q == DRN_END) begin
                    state_d = S_DONE;
                end else begin
                    drn_cnt_d = drn_cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            clr_cnt_q    <= '0;
            drn_cnt_q    <= '0;
            px_q         <= '0;
            py_q         <= '0;
            frame_q      <= '0;
            last_frame_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            drn_cnt_q    <= drn_cnt_d;
            px_q         <= px_d;
            py_q         <= py_d;
            frame_q      <= frame_d;
            last_frame_q <= last_frame_d;
        end
    end

    // conv1 reset: registered so it is low exactly for the cycles spent in CLR.
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_rst_n_q <= 1'b0;
        end else begin
            conv_rst_n_q <= (state_d != S_CLR);
        end
    end

    // Tag for the current beat: only window positions that yield a conv1 output.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = beat && (px_q >= K_EDGE) && (py_q >= K_EDGE);
        tag_in.x     = out_coord(px_q);
        tag_in.y     = out_coord(py_q);
        tag_in.last  = (px_q == X_MAX) && (py_q == Y_MAX);
    end

    conv1_frame_sched_tag_pipe #(
        .DEPTH (CONV_LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .clr_i (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign out_valid = tag_out.valid;
    assign out_x     = tag_out.x;
    assign out_y     = tag_out.y;
    assign out_last  = tag_out.last;

endmodule

// File: tb/tb_conv1_frame_sched.sv
// Randomised scoreboard bench for conv1_frame_sched: the driver predicts each
// output from the beat count alone, the monitor pops and compares.
module tb_conv1_frame_sched;

    localparam int W         = 28;
    localparam int H         = 28;
    localparam int KK        = 5;
    localparam int LAT       = 2;
    localparam int FRAME_PIX = W * H;
    localparam int FRAME_OUT = (W - KK + 1) * (H - KK + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] num_frames;
    logic       busy;
    logic       done;
    logic [7:0] frame_idx;
    logic [7:0] src_data;
    logic       src_valid;
    logic       src_ready;
    logic       conv_rst_n;
    logic [7:0] conv_data_in;
    logic       conv_data_in_valid;
    logic       out_valid;
    logic [4:0] out_x;
    logic [4:0] out_y;
    logic       out_last;

    conv1_frame_sched dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .num_frames         (num_frames),
        .busy               (busy),
        .done               (done),
        .frame_idx          (frame_idx),
        .src_data           (src_data),
        .src_valid          (src_valid),
        .src_ready          (src_ready),
        .conv_rst_n         (conv_rst_n),
        .conv_data_in       (conv_data_in),
        .conv_data_in_valid (conv_data_in_valid),
        .out_valid          (out_valid),
        .out_x              (out_x),
        .out_y              (out_y),
        .out_last           (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int x;
        int y;
        int last;
    } exp_t;

    exp_t sb[$];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int out_cnt, done_cnt, clr_low, ready_cnt, exp_done_cyc;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every presented output against the scoreboard head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (out_valid === 1'b1) begin
            out_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_cycle", cyc, e.due);
                check("out_x", int'(out_x), e.x);
                check("out_y", int'(out_y), e.y);
                check("out_last", int'(out_last), e.last);
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            check("done_cycle", cyc, exp_done_cyc);
        end
        if (busy === 1'b1 && conv_rst_n === 1'b0) clr_low++;
        if (src_ready === 1'b1) ready_cnt++;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_frame_idx"}, int'(frame_idx), 0);
        check({tag, "_src_ready"}, int'(src_ready), 0);
        check({tag, "_conv_rst_n"}, int'(conv_rst_n), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_x"}, int'(out_x), 0);
        check({tag, "_out_y"}, int'(out_y), 0);
        check({tag, "_out_last"}, int'(out_last), 0);
    endtask

    // One job: nf frames, gap = percent of cycles with src_valid low,
    // restart_at = beat count at which a stray start is pulsed (0 = none),
    // abort_at = beat count after which rst is asserted (0 = none).
    task automatic run_job(input int nf, input int gap, input int restart_at, input int abort_at);
        int beats;
        int job_beats;
        int budget;
        int n, pos, px, py;
        exp_t e;

        job_beats    = nf * FRAME_PIX;
        out_cnt      = 0;
        done_cnt     = 0;
        clr_low      = 0;
        ready_cnt    = 0;
        exp_done_cyc = -1;

        @(posedge clk); #1;
        start      = 1'b1;
        num_frames = 8'(nf);
        if (nf == 0) exp_done_cyc = cyc + 1;
        @(posedge clk); #1;
        start      = 1'b0;
        num_frames = 8'($urandom);

        beats  = 0;
        budget = 0;
        while (beats < job_beats && !(abort_at > 0 && beats == abort_at)
               && budget < job_beats * 4 + 50) begin
            src_valid = ($urandom_range(99) >= gap);
            src_data  = 8'($urandom);
            if (restart_at > 0 && beats == restart_at) begin
                start      = 1'b1;
                num_frames = 8'd0;
            end
            @(negedge clk);
            if (src_valid && src_ready === 1'b1) begin
                n   = beats;
                pos = n % FRAME_PIX;
                px  = pos % W;
                py  = pos / W;
                check("frame_idx", int'(frame_idx), (n / FRAME_PIX) % 256);
                check("busy_in_feed", int'(busy), 1);
                check("conv_data_in", int'(conv_data_in), int'(src_data));
                check("conv_data_in_valid", int'(conv_data_in_valid), 1);
                if (px >= KK - 1 && py >= KK - 1) begin
                    e.due  = cyc + LAT;
                    e.x    = px - (KK - 1);
                    e.y    = py - (KK - 1);
                    e.last = (px == W - 1 && py == H - 1) ? 1 : 0;
                    sb.push_back(e);
                end
                beats++;
                if (beats == job_beats) exp_done_cyc = cyc + LAT;
            end
            @(posedge clk); #1;
            start  = 1'b0;
            budget++;
        end
        src_valid = 1'b0;

        if (abort_at > 0) begin
            check("beats_before_abort", beats, abort_at);
            rst = 1'b1;
            @(posedge clk); #1;
            sb.delete();
            @(negedge clk);
            check_reset_outputs("abort");
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (4) @(negedge clk);
            check("abort_no_done", done_cnt, 0);
            check("abort_idle", int'(busy), 0);
            return;
        end

        check("beats_accepted", beats, job_beats);
        for (int i = 0; i < 40 && done_cnt == 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("done_pulses", done_cnt, 1);
        check("out_valid_count", out_cnt, nf * FRAME_OUT);
        check("clr_low_cycles", clr_low, (nf == 0) ? 0 : 2);
        check("scoreboard_empty", sb.size(), 0);
        check("idle_after_job", int'(busy), 0);
        if (nf == 0) check("no_ready_zero_job", ready_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        num_frames = 8'd0;
        src_valid  = 1'b0;
        src_data   = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_job(1, 0, 0, 0);     // one frame, no gaps
        run_job(1, 50, 0, 0);    // one frame, 50% source gaps
        run_job(3, 10, 0, 0);    // three back-to-back frames
        run_job(0, 0, 0, 0);     // empty job
        run_job(1, 20, 100, 0);  // stray start during FEED
        run_job(1, 0, 0, 400);   // reset at beat 400
        run_job(1, 30, 0, 0);    // clean frame after the abort

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
